// File: rtl/apb_timer_periph_if.sv
// APB slave port bundle for the timer peripheral slot.
interface apb_timer_periph_if;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
                  input  PRDATA, PREADY);
  modport slave  (input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
                  output PRDATA, PREADY);
endinterface

// File: rtl/apb_timer_periph.sv
// APB timer: prescaler, up-counter with auto-reload compare, one-shot or
// periodic mode, sticky update flag and level interrupt.
module apb_timer_periph #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_timer_periph_if.slave apb,
  output logic              irq
);
  logic             en, ar, ie, uif;
  logic [PSC_W-1:0] psc, pcnt;
  logic [CNT_W-1:0] arr, tcnt;
  logic [2:0]       sel;
  logic             setup, wr;
  logic             wr_tcr, wr_psc, wr_arr, wr_tcnt, wr_tsr;
  logic             clr, tick, ovf;
  logic [31:0]      rd_mux;

  assign sel     = apb.PADDR[4:2];
  assign setup   = apb.PSEL & ~apb.PENABLE;
  assign wr      = apb.PSEL & apb.PENABLE & apb.PWRITE & apb.PREADY;
  assign wr_tcr  = wr & (sel == 3'd0);
  assign wr_psc  = wr & (sel == 3'd1);
  assign wr_arr  = wr & (sel == 3'd2);
  assign wr_tcnt = wr & (sel == 3'd3);
  assign wr_tsr  = wr & (sel == 3'd4);
  assign clr     = wr_tcr & apb.PWDATA[1];

  // A software counter load (CLR or TCNT write) swallows any tick on the same edge.
  assign tick = en & (pcnt == psc) & ~clr & ~wr_tcnt;
  assign ovf  = tick & (tcnt >= arr);
  assign irq  = uif & ie;

  // Register read mux; unused bits and unmapped offsets read as zero.
  always_comb begin
    rd_mux = '0;
    case (sel)
      3'd0:    rd_mux[3:0] = {ie, ar, 1'b0, en};
      3'd1:    rd_mux[PSC_W-1:0] = psc;
      3'd2:    rd_mux[CNT_W-1:0] = arr;
      3'd3:    rd_mux[CNT_W-1:0] = tcnt;
      3'd4:    rd_mux[0] = uif;
      default: rd_mux = '0;
    endcase
  end

  // Zero-wait APB handshake: PREADY high only in the access cycle, read data captured at setup.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      apb.PREADY <= 1'b0;
      apb.PRDATA <= '0;
    end else begin
      apb.PREADY <= setup;
      if (setup && !apb.PWRITE) apb.PRDATA <= rd_mux;
    end
  end

  // Control and configuration registers; a one-shot overflow drops EN unless software writes TCR.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      en  <= 1'b0;
      ar  <= 1'b0;
      ie  <= 1'b0;
      psc <= '0;
      arr <= '1;
    end else begin
      if (wr_tcr) begin
        en <= apb.PWDATA[0];
        ar <= apb.PWDATA[2];
        ie <= apb.PWDATA[3];
      end else if (ovf && !ar) begin
        en <= 1'b0;
      end
      if (wr_psc) psc <= apb.PWDATA[PSC_W-1:0];
      if (wr_arr) arr <= apb.PWDATA[CNT_W-1:0];
    end
  end

  // Prescaler and main counter, with software loads taking priority over ticks.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      tcnt <= '0;
      pcnt <= '0;
    end else if (clr) begin
      tcnt <= '0;
      pcnt <= '0;
    end else if (wr_tcnt) begin
      tcnt <= apb.PWDATA[CNT_W-1:0];
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
      tcnt <= ovf ? '0 : tcnt + CNT_W'(1);
    end else if (en) begin
      pcnt <= pcnt + PSC_W'(1);
    end
  end

  // Sticky update flag; a hardware set beats a same-edge write-1-clear.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      uif <= 1'b0;
    end else if (ovf) begin
      uif <= 1'b1;
    end else if (wr_tsr && apb.PWDATA[0]) begin
      uif <= 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_timer_periph.sv
// Self-checking bench for apb_timer_periph: directed scenarios with literal
// expectations, then randomized APB traffic against a behavioural model.
module tb_apb_timer_periph;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic irq;
  int   n_checks = 0;
  int   n_errors = 0;

  apb_timer_periph_if bus ();

  apb_timer_periph #(.CNT_W(32), .PSC_W(16)) dut (
    .PCLK  (clk),
    .PRESET(rst_n),
    .apb   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state, reset values
  bit        m_en = 0, m_ar = 0, m_ie = 0, m_uif = 0, m_pready = 0;
  bit [15:0] m_psc = 0, m_pcnt = 0;
  bit [31:0] m_arr = 32'hFFFF_FFFF, m_tcnt = 0, m_prdata = 0;
  bit [2:0]  m_a;
  bit        m_setup, m_wr, m_ovf;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit [31:0] mread(bit [2:0] a);
    case (a)
      3'd0:    return {28'd0, m_ie, m_ar, 1'b0, m_en};
      3'd1:    return {16'd0, m_psc};
      3'd2:    return m_arr;
      3'd3:    return m_tcnt;
      3'd4:    return {31'd0, m_uif};
      default: return 32'd0;
    endcase
  endfunction

  // Model: apply the register-map rules once per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_uif = 0; m_pready = 0;
      m_psc = 0; m_pcnt = 0; m_arr = 32'hFFFF_FFFF; m_tcnt = 0; m_prdata = 0;
    end else begin
      m_a     = bus.PADDR[4:2];
      m_setup = bus.PSEL && !bus.PENABLE;
      m_wr    = bus.PSEL && bus.PENABLE && bus.PWRITE && m_pready;
      if (m_setup && !bus.PWRITE) m_prdata = mread(m_a);
      m_pready = m_setup;
      m_ovf = 0;
      if (m_wr && m_a == 0 && bus.PWDATA[1]) begin
        m_tcnt = 0; m_pcnt = 0;
      end else if (m_wr && m_a == 3) begin
        m_tcnt = bus.PWDATA; m_pcnt = 0;
      end else if (m_en) begin
        if (m_pcnt == m_psc) begin
          m_pcnt = 0;
          if (m_tcnt >= m_arr) begin m_ovf = 1; m_tcnt = 0; end
          else m_tcnt = m_tcnt + 1;
        end else m_pcnt = m_pcnt + 1;
      end
      if (m_ovf) m_uif = 1;
      else if (m_wr && m_a == 4 && bus.PWDATA[0]) m_uif = 0;
      if (m_wr && m_a == 0) begin
        m_en = bus.PWDATA[0]; m_ar = bus.PWDATA[2]; m_ie = bus.PWDATA[3];
      end else if (m_ovf && !m_ar) m_en = 0;
      if (m_wr && m_a == 1) m_psc = bus.PWDATA[15:0];
      if (m_wr && m_a == 2) m_arr = bus.PWDATA;
    end
  end

  // Compare DUT outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pready", bus.PREADY, {31'd0, m_pready});
      chk("prdata", bus.PRDATA, m_prdata);
      chk("irq", irq, {31'd0, m_uif & m_ie});
    end
  end

  // One 2-cycle transfer; called at posedge+1, returns at posedge+1 after the access edge.
  task automatic apb_xfer(input bit w, input bit [31:0] addr, input bit [31:0] d,
                          output bit [31:0] rd);
    bus.PSEL = 1; bus.PENABLE = 0; bus.PADDR = addr; bus.PWRITE = w; bus.PWDATA = d;
    @(posedge clk); #1;
    chk("pready_in_access", bus.PREADY, 1);
    bus.PENABLE = 1;
    @(posedge clk); #1;
    chk("pready_after_access", bus.PREADY, 0);
    rd = bus.PRDATA;
    bus.PSEL = 0; bus.PENABLE = 0;
  endtask

  task automatic wr_reg(input bit [31:0] addr, input bit [31:0] d);
    bit [31:0] rd;
    apb_xfer(1'b1, addr, d, rd);
  endtask

  task automatic rd_chk(input string nm, input bit [31:0] addr, input bit [31:0] exp);
    bit [31:0] rd;
    apb_xfer(1'b0, addr, 32'd0, rd);
    chk(nm, rd, exp);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  int n;
  int ra;
  bit rw;
  bit [31:0] rdat, rd;

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PADDR = 0; bus.PWRITE = 0; bus.PWDATA = 0;
    #1 rst_n = 0;
    // Reset held with random bus activity
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.PSEL = 1'($urandom); bus.PENABLE = 1'($urandom); bus.PWRITE = 1'($urandom);
      bus.PADDR = $urandom; bus.PWDATA = $urandom;
    end
    bus.PSEL = 0; bus.PENABLE = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    rd_chk("rst_tcr", 32'h00, 32'h0);
    rd_chk("rst_psc", 32'h04, 32'h0);
    rd_chk("rst_arr", 32'h08, 32'hFFFF_FFFF);
    rd_chk("rst_tcnt", 32'h0C, 32'h0);
    rd_chk("rst_tsr", 32'h10, 32'h0);
    chk("rst_irq", irq, 0);

    // Periodic: PSC=3 ARR=4 -> overflow every 20 cycles
    wr_reg(32'h04, 3);
    wr_reg(32'h08, 4);
    wr_reg(32'h00, 32'b1101);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!irq && n < 100);
    chk("periodic_first_irq_cycles", n, 20);
    wr_reg(32'h10, 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!irq && n < 100);
    chk("periodic_second_irq_cycles", n, 18);
    rd_chk("periodic_tcnt_a", 32'h0C, 0);
    rd_chk("periodic_tcnt_b", 32'h0C, 0);
    rd_chk("periodic_tcnt_c", 32'h0C, 1);
    rd_chk("periodic_en_kept", 32'h00, 32'b1101);
    wr_reg(32'h00, 0);

    // One-shot: PSC=0 ARR=2
    wr_reg(32'h04, 0);
    wr_reg(32'h08, 2);
    wr_reg(32'h0C, 0);
    wr_reg(32'h10, 1);
    wr_reg(32'h00, 32'b0001);
    cycles(3);
    rd_chk("oneshot_uif", 32'h10, 1);
    rd_chk("oneshot_en_off", 32'h00, 0);
    rd_chk("oneshot_tcnt", 32'h0C, 0);
    cycles(50);
    rd_chk("oneshot_tcnt_hold", 32'h0C, 0);
    chk("oneshot_irq", irq, 0);

    // Collision: TSR write-1 lands on the overflow edge
    wr_reg(32'h08, 3);
    wr_reg(32'h0C, 0);
    wr_reg(32'h10, 1);
    wr_reg(32'h00, 32'b0101);
    cycles(2);
    wr_reg(32'h10, 1);
    rd_chk("collision_uif_set_wins", 32'h10, 1);
    cycles(1);
    wr_reg(32'h10, 1);
    rd_chk("collision_later_clear", 32'h10, 0);
    wr_reg(32'h00, 0);

    // TCNT load on a tick edge
    wr_reg(32'h04, 1);
    wr_reg(32'h08, 100);
    wr_reg(32'h0C, 0);
    wr_reg(32'h00, 32'b0001);
    cycles(2);
    wr_reg(32'h0C, 7);
    rd_chk("load_tcnt7", 32'h0C, 7);
    rd_chk("load_pcnt_restart", 32'h0C, 8);

    // ARR lowered below TCNT
    wr_reg(32'h00, 0);
    wr_reg(32'h0C, 9);
    wr_reg(32'h08, 1);
    wr_reg(32'h10, 1);
    wr_reg(32'h00, 32'b0001);
    cycles(2);
    rd_chk("arr_low_tcnt_wrap", 32'h0C, 0);
    rd_chk("arr_low_uif", 32'h10, 1);

    // CLR keeps EN
    wr_reg(32'h00, 32'b0111);
    rd_chk("clr_tcnt_zero", 32'h0C, 0);
    rd_chk("clr_keeps_en", 32'h00, 32'b0101);

    // Unmapped offsets
    rd_chk("unmapped_18", 32'h18, 0);
    wr_reg(32'h1C, 32'hDEAD_BEEF);
    rd_chk("unmapped_1c", 32'h1C, 0);

    // Async reset mid-count with UIF=1 and IE=1
    wr_reg(32'h00, 32'b1000);
    wr_reg(32'h0C, 3);
    rd_chk("pre_reset_tcnt", 32'h0C, 3);
    chk("pre_reset_irq", irq, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_pready", bus.PREADY, 0);
    chk("async_rst_prdata", bus.PRDATA, 0);
    chk("async_rst_irq", irq, 0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    rd_chk("post_reset_tcnt", 32'h0C, 0);
    rd_chk("post_reset_tsr", 32'h10, 0);

    // Randomized traffic checked cycle-by-cycle against the model
    for (int i = 0; i < 400; i++) begin
      ra = $urandom_range(0, 7);
      rw = 1'($urandom);
      case (ra)
        0:       rdat = $urandom_range(0, 15);
        1:       rdat = $urandom_range(0, 3);
        2:       rdat = $urandom_range(0, 12);
        3:       rdat = $urandom_range(0, 15);
        default: rdat = $urandom;
      endcase
      apb_xfer(rw, (32'(ra) << 2) | ($urandom & ~32'h1C), rdat, rd);
      cycles($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
